// File: rtl/rng_checker.sv
// -----------------------------------------------------------------------------
// rng_checker
//
// Watches a stream of 32-bit words that should be consecutive states of the
// LFSR x^32 + x^22 + x^2 + x^1 + 1 (shift left, feedback into bit 0). It
// synchronises to the stream, declares lock after LOCK_COUNT consecutive
// correct predictions, and while locked flags and counts every word that
// differs from the prediction. LOSS_COUNT consecutive mispredictions drop lock
// and the checker resynchronises on the offending word.
//
// Parameters
//   LOCK_COUNT   consecutive correct predictions needed to lock   (1..255)
//   LOSS_COUNT   consecutive mispredictions that drop lock        (1..255)
//
// Ports
//   clk           in   1   sole clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   data_valid    in   1   data_in carries one LFSR word this cycle
//   data_in       in   32  observed LFSR state word
//   clear_counts  in   1   synchronous clear of err_count (wins over increment)
//   locked        out  1   checker is in the LOCKED state (registered)
//   error         out  1   one-cycle pulse per mismatch while locked
//   err_count     out  16  saturating mismatch count
// -----------------------------------------------------------------------------
module rng_checker #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    input  logic        clear_counts,
    output logic        locked,
    output logic        error,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Eight bits cover the full supported range of both thresholds.
    localparam logic [7:0]  LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [7:0]  LOSS_TGT = 8'(LOSS_COUNT);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // One step of the Fibonacci LFSR being checked.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [31:0] ref_q,       ref_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  miss_cnt_q,  miss_cnt_d;

    logic        locked_d;
    logic        error_d;
    logic [15:0] err_count_d;

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    logic [31:0] predicted;
    logic        hit;
    logic        word_nz;
    logic [7:0]  match_inc;
    logic [7:0]  miss_inc;
    logic        miss_event;

    assign predicted = lfsr_next(ref_q);
    assign hit       = (data_in == predicted);
    assign word_nz   = (data_in != 32'd0);
    assign match_inc = match_cnt_q + 8'd1;
    assign miss_inc  = miss_cnt_q + 8'd1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every flop below is assigned with <= so all of them sample the
    // pre-edge values; a blocking = here would let later statements see
    // already-updated state and create simulation/synthesis mismatches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked      <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked      <= locked_d;
            error       <= error_d;
            err_count   <= err_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in this block gets a hold value first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        // Idle cycles (data_valid low) leave everything untouched.
        if (data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    // All-zero is the LFSR lockup state and cannot seed a
                    // sequence, so it is ignored here.
                    if (word_nz) begin
                        ref_d       = data_in;
                        match_cnt_d = '0;
                        state_d     = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (hit) begin
                        ref_d       = data_in;
                        match_cnt_d = match_inc;
                        if (match_inc >= LOCK_TGT) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (word_nz) begin
                        // Restart synchronisation on the new word.
                        ref_d       = data_in;
                        match_cnt_d = '0;
                    end else begin
                        state_d     = ST_IDLE;
                        ref_d       = '0;
                        match_cnt_d = '0;
                    end
                end

                ST_LOCKED: begin
                    if (hit) begin
                        ref_d      = data_in;
                        miss_cnt_d = '0;
                    end else if (miss_inc >= LOSS_TGT) begin
                        // Too many misses in a row: the stream has moved on.
                        // Resynchronise on the offending word if it can seed.
                        miss_cnt_d  = '0;
                        match_cnt_d = '0;
                        if (word_nz) begin
                            state_d = ST_SYNC;
                            ref_d   = data_in;
                        end else begin
                            state_d = ST_IDLE;
                            ref_d   = '0;
                        end
                    end else begin
                        // Free-run the reference so an isolated corrupted
                        // word does not poison the next prediction.
                        ref_d      = predicted;
                        miss_cnt_d = miss_inc;
                    end
                end

                default: begin
                    state_d     = ST_IDLE;
                    ref_d       = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (values registered on the next edge)
    // -------------------------------------------------------------------------
    always_comb begin
        // Only evaluations made in LOCKED can raise an error; the miss that
        // drops lock still counts.
        miss_event  = data_valid && (state_q == ST_LOCKED) && !hit;

        error_d     = miss_event;
        locked_d    = (state_d == ST_LOCKED);

        err_count_d = err_count;
        if (clear_counts) begin
            err_count_d = '0;
        end else if (miss_event && (err_count != CNT_MAX)) begin
            err_count_d = err_count + 16'd1;
        end
    end

endmodule
